// File: rtl/sid_pkg.sv
// Shared register map and bus-decay constants for the SID register file.
package sid_pkg;

    localparam int unsigned SID_DATA_W     = 8;
    localparam int unsigned SID_ADDR_W     = 5;
    localparam int unsigned SID_NUM_REGS   = 25;
    localparam int unsigned SID_NUM_VOICES = 3;
    localparam int unsigned SID_VOICE_STRIDE = 7;
    localparam int unsigned SID_DECAY_W    = 14;

    // Voice 0 register addresses; voices 1 and 2 follow at SID_VOICE_STRIDE.
    localparam logic [SID_ADDR_W-1:0] SID_FREQ_LO  = 5'h00;
    localparam logic [SID_ADDR_W-1:0] SID_FREQ_HI  = 5'h01;
    localparam logic [SID_ADDR_W-1:0] SID_PW_LO    = 5'h02;
    localparam logic [SID_ADDR_W-1:0] SID_PW_HI    = 5'h03;
    localparam logic [SID_ADDR_W-1:0] SID_CTRL     = 5'h04;
    localparam logic [SID_ADDR_W-1:0] SID_ATT_DEC  = 5'h05;
    localparam logic [SID_ADDR_W-1:0] SID_SUS_REL  = 5'h06;
    localparam logic [SID_ADDR_W-1:0] SID_FC_LO    = 5'h15;
    localparam logic [SID_ADDR_W-1:0] SID_FC_HI    = 5'h16;
    localparam logic [SID_ADDR_W-1:0] SID_RES_FILT = 5'h17;
    localparam logic [SID_ADDR_W-1:0] SID_MODE_VOL = 5'h18;
    localparam logic [SID_ADDR_W-1:0] SID_POT_X    = 5'h19;
    localparam logic [SID_ADDR_W-1:0] SID_POT_Y    = 5'h1A;
    localparam logic [SID_ADDR_W-1:0] SID_OSC3     = 5'h1B;
    localparam logic [SID_ADDR_W-1:0] SID_ENV3     = 5'h1C;

    // Bus latch clears once the counter reaches this value.
    localparam logic [SID_DECAY_W-1:0] SID_DECAY_LIMIT = 14'h2000;

endpackage : sid_pkg

// File: rtl/sid_bus_latch.sv
// Data-bus latch: captures every write; optional decay clears it after
// SID_DECAY_LIMIT ce_1m ticks without a write (macro SID_BUS_DECAY_EN).
// Ports: i_clk, i_rst_n (async active-low), i_ce_1m tick, i_wr write strobe,
//        i_wr_data write data, o_latch latched bus value.
module sid_bus_latch
    import sid_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ce_1m,
    input  logic                  i_wr,
    input  logic [SID_DATA_W-1:0] i_wr_data,
    output logic [SID_DATA_W-1:0] o_latch
);

    logic [SID_DATA_W-1:0] r_latch;

`ifdef SID_BUS_DECAY_EN
    logic [SID_DECAY_W-1:0] r_count;
    logic                   w_tick;
    logic                   w_expire;

    // Count only while something is latched; stop once saturated.
    assign w_tick   = i_ce_1m && (r_latch != '0) && (r_count != SID_DECAY_LIMIT);
    assign w_expire = w_tick && (r_count == SID_DECAY_LIMIT - SID_DECAY_W'(1));

    // A write takes priority over a simultaneous expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_latch <= '0;
            r_count <= '0;
        end else if (i_wr) begin
            r_latch <= i_wr_data;
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + SID_DECAY_W'(1);
            if (w_expire) begin
                r_latch <= '0;
            end
        end
    end
`else
    logic w_unused_ce;
    assign w_unused_ce = i_ce_1m;

    // Latch holds the last written value indefinitely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_latch <= '0;
        end else if (i_wr) begin
            r_latch <= i_wr_data;
        end
    end
`endif

    assign o_latch = r_latch;

endmodule : sid_bus_latch

// File: rtl/sid_regfile.sv
// SID register file: 25 write-only control registers, registered readback of
// paddles / osc3 / env3, and an open-bus latch for all other reads.
// Optional bus decay is enabled with macro SID_BUS_DECAY_EN.
// Ports: clock, reset_n (async active-low), ce_1m, cs/we/addr/data_in bus,
//        data_out read data, per-voice freq/pw/ctrl/att_dec/sus_rel,
//        filter_fc, res_filt, mode_vol, pot_x/pot_y/osc3/env3 read sources.
module sid_regfile
    import sid_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ce_1m,
    input  logic                  cs,
    input  logic                  we,
    input  logic [SID_ADDR_W-1:0] addr,
    input  logic [SID_DATA_W-1:0] data_in,
    output logic [SID_DATA_W-1:0] data_out,
    output logic [15:0]           voice_freq [0:SID_NUM_VOICES-1],
    output logic [11:0]           voice_pw   [0:SID_NUM_VOICES-1],
    output logic [7:0]            voice_ctrl [0:SID_NUM_VOICES-1],
    output logic [7:0]            att_dec    [0:SID_NUM_VOICES-1],
    output logic [7:0]            sus_rel    [0:SID_NUM_VOICES-1],
    output logic [10:0]           filter_fc,
    output logic [7:0]            res_filt,
    output logic [7:0]            mode_vol,
    input  logic [7:0]            pot_x,
    input  logic [7:0]            pot_y,
    input  logic [7:0]            osc3,
    input  logic [7:0]            env3
);

    logic [SID_DATA_W-1:0] r_regs [0:SID_NUM_REGS-1];
    logic [SID_DATA_W-1:0] r_data_out;
    logic [SID_DATA_W-1:0] w_latch;
    logic                  w_wr;
    logic                  w_rd;

    assign w_wr = cs && we;
    assign w_rd = cs && !we;

    // Register array; addresses above SID_MODE_VOL match no entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SID_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SID_NUM_REGS; i++) begin
                if (w_wr && (addr == SID_ADDR_W'(i))) begin
                    r_regs[i] <= data_in;
                end
            end
        end
    end

    // Read sources are sampled on the read edge and held until the next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            case (addr)
                SID_POT_X: r_data_out <= pot_x;
                SID_POT_Y: r_data_out <= pot_y;
                SID_OSC3:  r_data_out <= osc3;
                SID_ENV3:  r_data_out <= env3;
                default:   r_data_out <= w_latch;
            endcase
        end
    end

    sid_bus_latch u_bus_latch (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_ce_1m   (ce_1m),
        .i_wr      (w_wr),
        .i_wr_data (data_in),
        .o_latch   (w_latch)
    );

    // Per-voice register views; pulse-width hi upper nibble is not exported.
    for (genvar v = 0; v < SID_NUM_VOICES; v++) begin : g_voice
        localparam int unsigned BASE = v * SID_VOICE_STRIDE;
        assign voice_freq[v] = {r_regs[BASE + 32'(SID_FREQ_HI)], r_regs[BASE + 32'(SID_FREQ_LO)]};
        assign voice_pw[v]   = {r_regs[BASE + 32'(SID_PW_HI)][3:0], r_regs[BASE + 32'(SID_PW_LO)]};
        assign voice_ctrl[v] = r_regs[BASE + 32'(SID_CTRL)];
        assign att_dec[v]    = r_regs[BASE + 32'(SID_ATT_DEC)];
        assign sus_rel[v]    = r_regs[BASE + 32'(SID_SUS_REL)];
    end

    assign filter_fc = {r_regs[SID_FC_HI], r_regs[SID_FC_LO][2:0]};
    assign res_filt  = r_regs[SID_RES_FILT];
    assign mode_vol  = r_regs[SID_MODE_VOL];
    assign data_out  = r_data_out;

endmodule : sid_regfile

// File: tb/tb_sid_regfile.sv
// Directed self-checking bench for sid_regfile.
module tb_sid_regfile;

    logic        clock;
    logic        reset_n;
    logic        ce_1m;
    logic        cs;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] voice_freq [0:2];
    logic [11:0] voice_pw   [0:2];
    logic [7:0]  voice_ctrl [0:2];
    logic [7:0]  att_dec    [0:2];
    logic [7:0]  sus_rel    [0:2];
    logic [10:0] filter_fc;
    logic [7:0]  res_filt;
    logic [7:0]  mode_vol;
    logic [7:0]  pot_x;
    logic [7:0]  pot_y;
    logic [7:0]  osc3;
    logic [7:0]  env3;

    int checks = 0;
    int errors = 0;

    sid_regfile dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ce_1m      (ce_1m),
        .cs         (cs),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .voice_freq (voice_freq),
        .voice_pw   (voice_pw),
        .voice_ctrl (voice_ctrl),
        .att_dec    (att_dec),
        .sus_rel    (sus_rel),
        .filter_fc  (filter_fc),
        .res_filt   (res_filt),
        .mode_vol   (mode_vol),
        .pot_x      (pot_x),
        .pot_y      (pot_y),
        .osc3       (osc3),
        .env3       (env3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clock);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clock);
        cs = 1'b0;
    endtask

    task automatic tick(input int n);
        ce_1m = 1'b1;
        repeat (n) @(negedge clock);
        ce_1m = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [15:0] acc;
        acc = {8'h00, data_out} | 16'(filter_fc) | {8'h00, res_filt} | {8'h00, mode_vol};
        for (int v = 0; v < 3; v++) begin
            acc = acc | voice_freq[v] | 16'(voice_pw[v]) | {8'h00, voice_ctrl[v]}
                      | {8'h00, att_dec[v]} | {8'h00, sus_rel[v]};
        end
        check(tag, acc, 16'h0000);
    endtask

    initial begin
        reset_n = 1'b0; ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
        addr = '0; data_in = '0;
        pot_x = 8'h3C; pot_y = 8'hC3; osc3 = 8'h5A; env3 = 8'h00;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Envelope parameters for voice 0 only.
        wr(5'h05, 8'h9A);
        check("att_dec0", {8'h00, att_dec[0]}, 16'h009A);
        wr(5'h06, 8'hF3);
        check("sus_rel0", {8'h00, sus_rel[0]}, 16'h00F3);
        check("att_dec12", {att_dec[1], att_dec[2]}, 16'h0000);
        check("sus_rel12", {sus_rel[1], sus_rel[2]}, 16'h0000);

        // Gate on then off.
        wr(5'h04, 8'h41);
        check("gate_on", {15'h0, voice_ctrl[0][0]}, 16'h0001);
        wr(5'h04, 8'h40);
        check("gate_off", {15'h0, voice_ctrl[0][0]}, 16'h0000);

        // Multi-byte views and masking.
        wr(5'h02, 8'hCD);
        wr(5'h03, 8'hAB);
        check("pw0_masked", 16'(voice_pw[0]), 16'h0BCD);
        wr(5'h07, 8'h34);
        wr(5'h08, 8'h12);
        check("freq1", voice_freq[1], 16'h1234);
        wr(5'h15, 8'hFF);
        wr(5'h16, 8'h80);
        check("filter_fc", 16'(filter_fc), 16'h0407);
        wr(5'h17, 8'hE1);
        check("res_filt", {8'h00, res_filt}, 16'h00E1);

        // Sampled read sources.
        rd(5'h19);
        check("rd_pot_x", {8'h00, data_out}, 16'h003C);
        rd(5'h1A);
        check("rd_pot_y", {8'h00, data_out}, 16'h00C3);
        rd(5'h1B);
        check("rd_osc3", {8'h00, data_out}, 16'h005A);
        env3 = 8'h7F;
        rd(5'h1C);
        check("rd_env3", {8'h00, data_out}, 16'h007F);
        env3 = 8'h10;
        repeat (2) @(negedge clock);
        check("env3_hold", {8'h00, data_out}, 16'h007F);

        // Bus latch readback and decay.
        wr(5'h12, 8'h55);
        check("ctrl2", {8'h00, voice_ctrl[2]}, 16'h0055);
        rd(5'h00);
        check("latch_55", {8'h00, data_out}, 16'h0055);
        check("read_no_side", {voice_ctrl[2], att_dec[0]}, 16'h559A);
        tick(8191);
        rd(5'h00);
        check("latch_8191", {8'h00, data_out}, 16'h0055);
        tick(1);
        rd(5'h00);
`ifdef SID_BUS_DECAY_EN
        check("latch_decayed", {8'h00, data_out}, 16'h0000);
`else
        check("latch_held", {8'h00, data_out}, 16'h0055);
`endif

        // Unmapped write, coinciding with the last decay tick.
        wr(5'h1F, 8'h33);
        tick(8191);
        ce_1m = 1'b1;
        wr(5'h1D, 8'hAA);
        ce_1m = 1'b0;
        check("unmapped_regs", {mode_vol, res_filt}, 16'h00E1);
        check("unmapped_v", {voice_ctrl[2], sus_rel[0]}, 16'h55F3);
        rd(5'h1D);
        check("rd_1d", {8'h00, data_out}, 16'h00AA);
        tick(8191);
        rd(5'h1D);
        check("write_wins", {8'h00, data_out}, 16'h00AA);

        // Asynchronous reset mid-stream, then release with access pending.
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        cs = 1'b1; we = 1'b1; addr = 5'h17; data_in = 8'h22;
        @(negedge clock);
        check("held_in_reset", {8'h00, res_filt}, 16'h0000);
        addr = 5'h18; data_in = 8'h0F;
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        cs = 1'b0; we = 1'b0;
        check("mode_vol_after", {8'h00, mode_vol}, 16'h000F);
        check("res_filt_after", {8'h00, res_filt}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sid_regfile
